audio_mix_dac: RTL and testbench

Multi-channel successor to the single 8-bit PWM audio output path. Accepts CHANNELS independent offset-binary sample streams, each through its own FIFO. Pops one sample per channel on a programmable sample-rate tick, applies per-channel gain, sums with saturation, and drives a first-order sigma-delta 1-bit output. Sits between the sample sources (SPI link state machine / SD read path) and the analog output pin.

---
 rtl/audio_mix_dac.sv | 187 ++++++++++++++++++
 tb/tb_audio_mix_dac.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_dac.sv
// audio_mix_dac: per-channel sample FIFOs feeding a tick-paced gain / mix
// pipeline with saturation, followed by a first-order sigma-delta modulator
// that produces the 1-bit analog bitstream.
module audio_mix_dac #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int GAIN_W     = 4,
  parameter int DIV        = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  output logic [CHANNELS-1:0]        in_ready,
  input  logic [CHANNELS*GAIN_W-1:0] gain,
  input  logic                       underrun_clr,
  output logic [CHANNELS-1:0]        underrun,
  output logic [WIDTH-1:0]           mix_out,
  output logic                       mix_valid,
  output logic                       analog
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int TW     = $clog2(DIV);
  localparam int CHW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int MUL_W  = WIDTH + GAIN_W + 2;
  localparam int PROD_W = WIDTH + GAIN_W + 1;
  // One spare bit above the full-width sum keeps the sign-extension count non-zero.
  localparam int SUM_W  = WIDTH + GAIN_W + CHW + 2;

  localparam logic [WIDTH-1:0]        MID      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO   = SUM_W'(-(2 ** (WIDTH - 1)));
  localparam logic [CW-1:0]           DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0]           CTR_LAST = TW'(DIV - 1);

  // Remove the offset, apply the Q1.(GAIN_W-1) gain, shift back (floor rounding).
  function automatic logic signed [PROD_W-1:0] scale(input logic [WIDTH-1:0]  smp,
                                                     input logic [GAIN_W-1:0] g);
    logic signed [MUL_W-1:0] s_ext;
    logic signed [MUL_W-1:0] g_ext;
    logic signed [MUL_W-1:0] full;
    s_ext = {{(MUL_W-WIDTH){1'b0}}, smp} - {{(MUL_W-WIDTH){1'b0}}, MID};
    g_ext = {{(MUL_W-GAIN_W){1'b0}}, g};
    full  = s_ext * g_ext;
    return PROD_W'(full >>> (GAIN_W - 1));
  endfunction

  // Sample-rate timer
  logic [TW-1:0] ctr_q, ctr_d;
  logic          tick;

  // FIFO state
  logic [WIDTH-1:0]             fifo_mem [CHANNELS][FIFO_DEPTH];
  logic [CHANNELS-1:0][AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CHANNELS-1:0][AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CHANNELS-1:0][CW-1:0]  count_q, count_d;
  logic [CHANNELS-1:0]          push, pop, ur_set;

  // Pipeline
  logic [CHANNELS-1:0][WIDTH-1:0]  samp_q, samp_d;
  logic [CHANNELS-1:0][GAIN_W-1:0] gain_q, gain_d;
  logic [CHANNELS-1:0][PROD_W-1:0] prod_q, prod_d;
  logic                            v1_q, v1_d;
  logic                            v2_q, v2_d;
  logic signed [SUM_W-1:0]         sum_c;
  logic [WIDTH-1:0]                mix_out_q, mix_out_d;
  logic                            mix_valid_q, mix_valid_d;
  logic [CHANNELS-1:0]             underrun_q, underrun_d;

  // Sigma-delta
  logic [WIDTH:0] acc_q, acc_d;
  logic           analog_q, analog_d;

  // Free-running tick counter, held at zero while paused.
  // NOTE: every comb output gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tick  = enable && (ctr_q == CTR_LAST);
    ctr_d = '0;
    if (enable && !tick) ctr_d = ctr_q + TW'(1);
  end

  // FIFO handshake, pop on tick, and pointer/count bookkeeping.
  always_comb begin
    in_ready = '0;
    push     = '0;
    pop      = '0;
    ur_set   = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !rst && (count_q[i] < DEPTH_C);
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = tick && (count_q[i] != '0);
      ur_set[i]   = tick && (count_q[i] == '0);
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // Sample storage write port.
  // NOTE: the sample array has no reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= in_data[i*WIDTH +: WIDTH];
    end
  end

  // Stage 0 capture at the tick (sample or silence, plus gain) and stage 1 scaling.
  always_comb begin
    samp_d = samp_q;
    gain_d = gain_q;
    if (tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        samp_d[i] = pop[i] ? fifo_mem[i][rd_ptr_q[i]] : MID;
        gain_d[i] = gain[i*GAIN_W +: GAIN_W];
      end
    end
    v1_d = tick;
    for (int i = 0; i < CHANNELS; i++) prod_d[i] = scale(samp_q[i], gain_q[i]);
    v2_d = v1_q;
  end

  // Stage 2 sum with saturation, output register, sticky flags and modulator.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < CHANNELS; i++)
      sum_c = sum_c + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    mix_out_d = mix_out_q;
    if (v2_q) begin
      if (sum_c > SAT_HI)      mix_out_d = '1;
      else if (sum_c < SAT_LO) mix_out_d = '0;
      else                     mix_out_d = sum_c[WIDTH-1:0] + MID;
    end
    mix_valid_d = v2_q;
    underrun_d  = ur_set | (underrun_q & ~{CHANNELS{underrun_clr}});
    acc_d       = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mix_out_q};
    analog_d    = acc_q[WIDTH];
  end

  // All control, pipeline and modulator state.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      samp_q      <= '0;
      gain_q      <= '0;
      prod_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      mix_out_q   <= MID;
      mix_valid_q <= 1'b0;
      underrun_q  <= '0;
      acc_q       <= '0;
      analog_q    <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      samp_q      <= samp_d;
      gain_q      <= gain_d;
      prod_q      <= prod_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      underrun_q  <= underrun_d;
      acc_q       <= acc_d;
      analog_q    <= analog_d;
    end
  end

  assign underrun  = underrun_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign analog    = analog_q;

endmodule

// File: tb/tb_audio_mix_dac.sv
// Directed bench for audio_mix_dac: table of single-tick mix vectors plus
// hand-written sequences for reset, flag collision, FIFO fill and modulator density.
module tb_audio_mix_dac;

  localparam int WIDTH      = 8;
  localparam int CHANNELS   = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int GAIN_W     = 4;
  localparam int DIV        = 16;
  // Steps from raising enable (just after an edge) to the cycle mix_valid is high.
  localparam int LAT        = DIV + 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic [7:0]  gain;
  logic        underrun_clr;
  logic [1:0]  underrun;
  logic [7:0]  mix_out;
  logic        mix_valid;
  logic        analog;

  audio_mix_dac #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .FIFO_DEPTH(FIFO_DEPTH),
    .GAIN_W(GAIN_W), .DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .gain(gain),
    .underrun_clr(underrun_clr), .underrun(underrun), .mix_out(mix_out),
    .mix_valid(mix_valid), .analog(analog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] g0;
    logic [3:0] g1;
    logic [1:0] push;
    logic [7:0] exp_mix;
    logic [1:0] exp_ur;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
    step();
    in_valid = '0;
  endtask

  task automatic pulse_clr();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
  endtask

  task automatic count_analog(output int ones);
    ones = 0;
    for (int c = 0; c < 256; c++) begin
      step();
      ones += int'(analog);
    end
  endtask

  // One tick's worth of mixing from a table record.
  task automatic run_vec(input int idx, input vec_t v);
    logic early;
    gain = {v.g1, v.g0};
    if (v.push != 2'b00) push_pair(v.push, v.d0, v.d1);
    pulse_clr();
    enable = 1'b1;
    early  = 1'b0;
    for (int n = 1; n < LAT; n++) begin
      step();
      if (mix_valid) early = 1'b1;
    end
    step();
    check($sformatf("vec%0d valid_timing", idx), {early, mix_valid}, 2'b01);
    check($sformatf("vec%0d mix_out", idx), mix_out, v.exp_mix);
    check($sformatf("vec%0d underrun", idx), underrun, v.exp_ur);
    enable = 1'b0;
    step();
    check($sformatf("vec%0d valid_width", idx), mix_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ones;

    //           d0     d1     g0    g1    push   exp    ur
    vecs[0]  = '{8'hC0, 8'h80, 4'd8, 4'd8, 2'b11, 8'hC0, 2'b00};
    vecs[1]  = '{8'hC0, 8'h80, 4'd4, 4'd8, 2'b11, 8'hA0, 2'b00};
    vecs[2]  = '{8'hFF, 8'hFF, 4'd8, 4'd8, 2'b11, 8'hFF, 2'b00};
    vecs[3]  = '{8'h00, 8'h00, 4'd15, 4'd15, 2'b11, 8'h00, 2'b00};
    vecs[4]  = '{8'h7F, 8'h80, 4'd4, 4'd8, 2'b11, 8'h7F, 2'b00};
    vecs[5]  = '{8'h81, 8'h7F, 4'd1, 4'd1, 2'b11, 8'h7F, 2'b00};
    vecs[6]  = '{8'h90, 8'hA0, 4'd8, 4'd15, 2'b11, 8'hCC, 2'b00};
    vecs[7]  = '{8'hFF, 8'h00, 4'd0, 4'd0, 2'b11, 8'h80, 2'b00};
    vecs[8]  = '{8'h40, 8'h00, 4'd8, 4'd15, 2'b01, 8'h40, 2'b10};
    vecs[9]  = '{8'h00, 8'h60, 4'd8, 4'd12, 2'b10, 8'h50, 2'b01};
    vecs[10] = '{8'h00, 8'h00, 4'd8, 4'd8, 2'b00, 8'h80, 2'b11};
    vecs[11] = '{8'hC0, 8'h00, 4'd8, 4'd8, 2'b01, 8'hC0, 2'b10};

    rst          = 1'b1;
    enable       = 1'b0;
    in_valid     = '0;
    in_data      = '0;
    gain         = {4'd8, 4'd8};
    underrun_clr = 1'b0;

    // Power-on reset
    #1;
    check("por in_ready during rst", in_ready, 2'b00);
    step();
    step();
    rst = 1'b0;
    #1;
    check("por mix_out", mix_out, 8'h80);
    check("por mix_valid", mix_valid, 1'b0);
    check("por underrun", underrun, 2'b00);
    check("por analog", analog, 1'b0);
    check("por in_ready", in_ready, 2'b11);
    step();

    // Table-driven mix vectors
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset mid-stream with samples queued and the timer part-way through a period
    push_pair(2'b11, 8'hF0, 8'hF0);
    push_pair(2'b11, 8'hF1, 8'hF1);
    enable = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst in_ready immediate", in_ready, 2'b00);
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("rst in_ready cycle%0d", n), in_ready, 2'b00);
    end
    enable = 1'b0;
    rst    = 1'b0;
    #1;
    check("rst mix_out", mix_out, 8'h80);
    check("rst underrun", underrun, 2'b00);
    check("rst analog", analog, 1'b0);
    check("rst mix_valid", mix_valid, 1'b0);
    check("rst in_ready after", in_ready, 2'b11);
    enable = 1'b1;
    repeat (LAT) step();
    check("rst fifo_empty underrun", underrun, 2'b11);
    check("rst fifo_empty mix_out", mix_out, 8'h80);
    enable = 1'b0;
    step();

    // Clear in the same cycle as a new ch1 underrun: set wins for ch1, ch0 clears
    gain = {4'd8, 4'd8};
    push_pair(2'b01, 8'hC0, 8'h00);
    enable = 1'b1;
    repeat (DIV - 1) step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("collide underrun", underrun, 2'b10);
    step();
    step();
    check("collide mix_valid", mix_valid, 1'b1);
    check("collide mix_out", mix_out, 8'hC0);
    enable = 1'b0;
    step();

    // Fill ch0 past capacity while paused
    pulse_clr();
    for (int k = 0; k <= FIFO_DEPTH; k++) begin
      push_pair(2'b01, 8'(8'h10 + k), 8'h00);
      check($sformatf("fill%0d in_ready0", k + 1), in_ready[0], (k + 1) < FIFO_DEPTH);
    end
    enable = 1'b1;
    repeat (DIV - 1) step();
    check("full in_ready0 in pop cycle", in_ready[0], 1'b0);
    in_valid = 2'b01;
    in_data  = {8'h00, 8'hEE};
    step();
    in_valid = '0;
    check("full in_ready0 after pop", in_ready[0], 1'b1);
    step();
    step();
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      check($sformatf("drain%0d mix_valid", k), mix_valid, 1'b1);
      check($sformatf("drain%0d mix_out", k), mix_out, 8'(8'h10 + k));
      if (k == FIFO_DEPTH - 1) check("drain last underrun0", underrun[0], 1'b0);
      repeat (DIV) step();
    end
    check("drained mix_valid", mix_valid, 1'b1);
    check("drained mix_out", mix_out, 8'h80);
    check("drained underrun0", underrun[0], 1'b1);
    enable = 1'b0;
    step();

    // Sigma-delta density at 0x40
    push_pair(2'b01, 8'h40, 8'h00);
    enable = 1'b1;
    repeat (LAT) step();
    check("sd40 mix_out", mix_out, 8'h40);
    enable = 1'b0;
    repeat (4) step();
    count_analog(ones);
    check("sd40 density", ones, 64);

    // Sigma-delta silent at 0x00
    push_pair(2'b01, 8'h00, 8'h00);
    enable = 1'b1;
    repeat (LAT) step();
    check("sd00 mix_out", mix_out, 8'h00);
    enable = 1'b0;
    repeat (4) step();
    count_analog(ones);
    check("sd00 density", ones, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
